fifo_rd_stream: RTL

//  Read-side drain engine for the dual-clock FIFO; sits entirely in the read clock domain.

---
 rtl/fifo_rd_pkg.sv | 18 +
 rtl/fifo_rd_skid_buf.sv | 51 +++++
 rtl/fifo_rd_stream.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fifo_rd_state_t;

   localparam int SKID_DEPTH = 2;
   localparam int STAT_W     = 32;

   // Frame counter width; a one-word frame still needs a 1-bit counter.
   function automatic int frame_cnt_width(input int frame_len);
      return (frame_len > 1) ? $clog2(frame_len) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry strict-FIFO skid buffer that absorbs the FIFO's one-cycle read latency.
module fifo_rd_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       cnt
);

   logic [WIDTH-1:0] ent0;
   logic [WIDTH-1:0] ent1;

   // NOTE: both entries are cleared on reset because the head feeds the output data port,
   // which must read zero out of reset; with only two entries this costs nothing notable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= 2'd0;
      end else begin
         unique case ({wr, pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= wr_data;
               else             ent1 <= wr_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the incoming word lands behind whatever remains.
               if (cnt == 2'd1) begin
                  ent0 <= wr_data;
               end else begin
                  ent0 <= ent1;
                  ent1 <= wr_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = ent0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops a 1-cycle-latency FIFO and re-presents words as a framed
// valid/ready stream. Optional FIFO_RD_STREAM_STATS_EN adds pop and stall counters.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FRAME_LEN  = 16
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [STAT_W-1:0]     stat_words,
   output logic [STAT_W-1:0]     stat_stall
`endif
);

   localparam int              FC_W    = frame_cnt_width(FRAME_LEN);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

   fifo_rd_state_t  state;
   logic            pend;
   logic [FC_W-1:0] frame_cnt;
   logic [1:0]      cnt;
   logic            pop;
   logic [2:0]      occ;

   assign m_valid = (cnt != 2'd0);
   assign pop     = m_valid & m_ready;
   // Occupancy the buffer will have once the in-flight word lands and this cycle's pop leaves.
   assign occ     = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};

   // Combinational from m_ready so a pop this cycle frees room for a read this cycle,
   // which is what keeps the stream at one word per cycle.
   assign fifo_rd_en = rd_rst_n & (state == RUN) & ~fifo_empty & (occ < 3'(SKID_DEPTH));

   assign m_last = m_valid & (frame_cnt == FC_LAST);
   assign busy   = (state != IDLE);

   fifo_rd_skid_buf #(
      .WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk     (rd_clk),
      .rst_n   (rd_rst_n),
      .wr      (pend),
      .wr_data (fifo_dout),
      .pop     (pop),
      .head    (m_data),
      .cnt     (cnt)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values and the block's statement order cannot change its meaning.
   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state     <= IDLE;
         pend      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         pend <= fifo_rd_en;
         if (pop) frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
         unique case (state)
            IDLE:  if (en) state <= RUN;
            RUN:   if (!en) state <= DRAIN;
            DRAIN: begin
               if (en)
                  state <= RUN;
               else if (!pend && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_STATS_EN
   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         stat_words <= '0;
         stat_stall <= '0;
      end else begin
         if (pop && stat_words != '1) stat_words <= stat_words + 1'b1;
         if (m_valid && !m_ready && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
      end
   end
`endif

endmodule
